// File: rtl/axi_lite_hex_pkg.sv
// Shared widths, read-FSM state type and the seven-segment lookup table
// for the AXI-Lite hex memory slave.
package axi_lite_hex_pkg;

  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 4;
  localparam int MEM_DEPTH = 1 << ADDR_W;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Active-high {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex_to_7seg.sv
// Purely combinational hex digit to active-high seven-segment decoder.
module hex_to_7seg
  import axi_lite_hex_pkg::*;
(
  input  logic [DATA_W-1:0] i_hex,
  output logic [6:0]        o_seg
);

  assign o_seg = SEG_LUT[i_hex];

endmodule

// File: rtl/axi_lite_hex_mem.sv
// AXI-Lite-style slave over a 16x4 register memory; last read value is shown
// on one seven-segment digit. Define AXI_SEG_ACTIVE_LOW_EN for a common-anode digit.
module axi_lite_hex_mem
  import axi_lite_hex_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  output logic [7:0]        disp_hex_r,
  input  logic              ms_arvalid,
  input  logic [ADDR_W-1:0] SWM_arADDR,
  output logic              sm_arready,
  input  logic              ms_rready,
  output logic              sm_rvalid,
  input  logic              ms_awvalid,
  output logic              sm_awready,
  input  logic              ms_wvalid,
  input  logic [DATA_W-1:0] SWM_wdata,
  output logic              sm_wready
);

`ifdef AXI_SEG_ACTIVE_LOW_EN
  localparam logic [7:0] DISP_INV = 8'hFF;
`else
  localparam logic [7:0] DISP_INV = 8'h00;
`endif

  rd_state_t         r_rd_state;
  rd_state_t         w_rd_next;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_mem [MEM_DEPTH];
  logic              r_aw_captured;
  logic              r_w_captured;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [7:0]        r_disp;

  logic [6:0]        w_seg;
  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_wr_commit;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;

  hex_to_7seg u_hex_to_7seg (
    .i_hex (r_rdata),
    .o_seg (w_seg)
  );

  assign w_aw_hs     = ms_awvalid && !r_aw_captured;
  assign w_w_hs      = ms_wvalid  && !r_w_captured;
  assign w_wr_commit = (r_aw_captured || w_aw_hs) && (r_w_captured || w_w_hs);
  assign w_wr_addr   = r_aw_captured ? r_wr_addr : SWM_arADDR;
  assign w_wr_data   = r_w_captured  ? r_wr_data : SWM_wdata;

  assign sm_awready  = !r_aw_captured;
  assign sm_wready   = !r_w_captured;
  assign disp_hex_r  = r_disp;

  // NOTE: every output of an always_comb is given a default first so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    w_rd_next  = r_rd_state;
    sm_arready = 1'b0;
    sm_rvalid  = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        sm_arready = 1'b1;
        if (ms_arvalid) w_rd_next = R_DATA;
      end
      R_DATA: begin
        sm_rvalid = 1'b1;
        if (ms_rready) w_rd_next = R_IDLE;
      end
      default: w_rd_next = R_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments make a same-edge read sample the memory before the write lands, so a colliding read returns old data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_state    <= R_IDLE;
      r_rdata       <= '0;
      r_disp        <= DISP_INV;
      r_aw_captured <= 1'b0;
      r_w_captured  <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      // NOTE: the memory is a small register file that must reload its identity contents on reset, so it is reset in a loop rather than inferred as RAM.
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= DATA_W'(i);
    end else begin
      r_rd_state <= w_rd_next;
      if (r_rd_state == R_IDLE && ms_arvalid) r_rdata <= r_mem[SWM_arADDR];
      if (r_rd_state == R_DATA && ms_rready) r_disp <= {1'b0, w_seg} ^ DISP_INV;

      if (w_wr_commit) begin
        r_mem[w_wr_addr] <= w_wr_data;
        r_aw_captured    <= 1'b0;
        r_w_captured     <= 1'b0;
      end else begin
        if (w_aw_hs) begin
          r_aw_captured <= 1'b1;
          r_wr_addr     <= SWM_arADDR;
        end
        if (w_w_hs) begin
          r_w_captured <= 1'b1;
          r_wr_data    <= SWM_wdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_hex_mem.sv
// Self-checking bench for axi_lite_hex_mem: table-driven read/write vectors
// with a display scoreboard, plus hand-written multi-cycle corner cases.
module tb_axi_lite_hex_mem;

`ifdef AXI_SEG_ACTIVE_LOW_EN
  localparam logic [7:0] INV = 8'hFF;
`else
  localparam logic [7:0] INV = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] disp_hex_r;
  logic       ms_arvalid;
  logic [3:0] SWM_arADDR;
  logic       sm_arready;
  logic       ms_rready;
  logic       sm_rvalid;
  logic       ms_awvalid;
  logic       sm_awready;
  logic       ms_wvalid;
  logic [3:0] SWM_wdata;
  logic       sm_wready;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] last_disp;

  typedef struct {
    logic       is_wr;
    logic [3:0] addr;
    logic [3:0] data;
    logic [7:0] exp_disp;
  } vec_t;

  vec_t vecs [20];

  axi_lite_hex_mem dut (
    .clk        (clk),
    .reset      (reset),
    .disp_hex_r (disp_hex_r),
    .ms_arvalid (ms_arvalid),
    .SWM_arADDR (SWM_arADDR),
    .sm_arready (sm_arready),
    .ms_rready  (ms_rready),
    .sm_rvalid  (sm_rvalid),
    .ms_awvalid (ms_awvalid),
    .sm_awready (sm_awready),
    .ms_wvalid  (ms_wvalid),
    .SWM_wdata  (SWM_wdata),
    .sm_wready  (sm_wready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h, required %02h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: got disp %02h, required a queued expectation (queue empty)", name, disp_hex_r);
    end else begin
      e = exp_q.pop_front();
      check(name, disp_hex_r, e);
      last_disp = e;
    end
  endtask

  task automatic do_read(input logic [3:0] addr, input logic [7:0] exp_seg);
    @(negedge clk);
    ms_arvalid = 1'b1;
    SWM_arADDR = addr;
    exp_q.push_back(exp_seg ^ INV);
    @(posedge clk); #1;
    check("rvalid_after_ar", {7'b0, sm_rvalid}, 8'd1);
    check("arready_after_ar", {7'b0, sm_arready}, 8'd0);
    @(negedge clk);
    ms_arvalid = 1'b0;
    ms_rready  = 1'b1;
    @(posedge clk); #1;
    check("rvalid_after_r", {7'b0, sm_rvalid}, 8'd0);
    pop_check("read_disp");
    @(negedge clk);
    ms_rready = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [3:0] data);
    @(negedge clk);
    ms_awvalid = 1'b1;
    ms_wvalid  = 1'b1;
    SWM_arADDR = addr;
    SWM_wdata  = data;
    @(posedge clk); #1;
    check("write_ready_pair", {6'b0, sm_awready, sm_wready}, 8'd3);
    @(negedge clk);
    ms_awvalid = 1'b0;
    ms_wvalid  = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 4'h3, 4'h0, 8'h4F};
    vecs[1]  = '{1'b1, 4'h3, 4'h4, 8'h00};
    vecs[2]  = '{1'b0, 4'h3, 4'h0, 8'h66};
    vecs[3]  = '{1'b0, 4'h4, 4'h0, 8'h66};
    vecs[4]  = '{1'b0, 4'h0, 4'h0, 8'h3F};
    vecs[5]  = '{1'b0, 4'hF, 4'h0, 8'h71};
    vecs[6]  = '{1'b1, 4'h8, 4'hB, 8'h00};
    vecs[7]  = '{1'b0, 4'h8, 4'h0, 8'h7C};
    vecs[8]  = '{1'b0, 4'h1, 4'h0, 8'h06};
    vecs[9]  = '{1'b0, 4'hD, 4'h0, 8'h5E};
    vecs[10] = '{1'b0, 4'h6, 4'h0, 8'h7D};
    vecs[11] = '{1'b0, 4'h7, 4'h0, 8'h07};
    vecs[12] = '{1'b0, 4'h9, 4'h0, 8'h6F};
    vecs[13] = '{1'b0, 4'hC, 4'h0, 8'h39};
    vecs[14] = '{1'b0, 4'hE, 4'h0, 8'h79};
    vecs[15] = '{1'b0, 4'h5, 4'h0, 8'h6D};
    vecs[16] = '{1'b0, 4'h2, 4'h0, 8'h5B};
    vecs[17] = '{1'b0, 4'hB, 4'h0, 8'h7C};
    vecs[18] = '{1'b1, 4'hB, 4'h0, 8'h00};
    vecs[19] = '{1'b0, 4'hB, 4'h0, 8'h3F};

    reset      = 1'b1;
    ms_arvalid = 1'b0;
    ms_rready  = 1'b0;
    ms_awvalid = 1'b0;
    ms_wvalid  = 1'b0;
    SWM_arADDR = 4'h0;
    SWM_wdata  = 4'h0;
    last_disp  = INV;

    repeat (2) @(posedge clk);
    #1;
    check("reset_disp", disp_hex_r, INV);
    check("reset_readies", {5'b0, sm_arready, sm_awready, sm_wready}, 8'd7);
    check("reset_rvalid", {7'b0, sm_rvalid}, 8'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data);
      else               do_read(vecs[i].addr, vecs[i].exp_disp);
    end

    // Split write: AW to 9 first, W with F two cycles later.
    @(negedge clk);
    ms_awvalid = 1'b1;
    SWM_arADDR = 4'h9;
    @(posedge clk); #1;
    check("split_aw_ready_pair", {6'b0, sm_awready, sm_wready}, 8'd1);
    @(negedge clk);
    ms_awvalid = 1'b0;
    SWM_arADDR = 4'h0;
    @(posedge clk); #1;
    check("split_hold_ready_pair", {6'b0, sm_awready, sm_wready}, 8'd1);
    @(negedge clk);
    ms_wvalid = 1'b1;
    SWM_wdata = 4'hF;
    @(posedge clk); #1;
    check("split_done_ready_pair", {6'b0, sm_awready, sm_wready}, 8'd3);
    @(negedge clk);
    ms_wvalid = 1'b0;
    SWM_wdata = 4'h0;
    do_read(4'h9, 8'h71);
    do_read(4'h0, 8'h3F);

    // Stalled read data channel.
    @(negedge clk);
    ms_arvalid = 1'b1;
    SWM_arADDR = 4'hA;
    exp_q.push_back(8'h77 ^ INV);
    @(negedge clk);
    ms_arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_hs_pair", {6'b0, sm_rvalid, sm_arready}, 8'd2);
      check("stall_disp", disp_hex_r, last_disp);
    end
    @(negedge clk);
    ms_rready = 1'b1;
    @(posedge clk); #1;
    pop_check("stall_release_disp");
    @(negedge clk);
    ms_rready = 1'b0;

    // Same-cycle read and write to address 2.
    @(negedge clk);
    ms_arvalid = 1'b1;
    ms_awvalid = 1'b1;
    ms_wvalid  = 1'b1;
    SWM_arADDR = 4'h2;
    SWM_wdata  = 4'h7;
    exp_q.push_back(8'h5B ^ INV);
    @(negedge clk);
    ms_arvalid = 1'b0;
    ms_awvalid = 1'b0;
    ms_wvalid  = 1'b0;
    ms_rready  = 1'b1;
    @(posedge clk); #1;
    pop_check("collide_old_disp");
    @(negedge clk);
    ms_rready = 1'b0;
    do_read(4'h2, 8'h07);

    // Reset while in R_DATA, with a half-captured write pending.
    @(negedge clk);
    ms_arvalid = 1'b1;
    ms_awvalid = 1'b1;
    SWM_arADDR = 4'h3;
    @(negedge clk);
    ms_arvalid = 1'b0;
    ms_awvalid = 1'b0;
    reset      = 1'b1;
    @(posedge clk); #1;
    check("midreset_rvalid", {7'b0, sm_rvalid}, 8'd0);
    check("midreset_disp", disp_hex_r, INV);
    check("midreset_readies", {5'b0, sm_arready, sm_awready, sm_wready}, 8'd7);
    @(negedge clk);
    reset = 1'b0;
    do_read(4'h3, 8'h4F);
    do_read(4'h8, 8'h7F);

    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
